// File: rtl/wb_fifo_pkg.sv
// Shared types for the Wishbone FIFO mailbox device: the bus FSM state, the
// termination kinds and the width of the wait-state counter.
package wb_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      TERM_NONE,
      TERM_ACK,
      TERM_ERR,
      TERM_RTY
   } term_t;

   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/wishbone_fifo_device_if.sv
// Wishbone B4 classic single-transfer link between a controller (master) and
// the FIFO device (slave). Signal names are seen from the device side.
interface wishbone_fifo_device_if #(
   parameter int DAT_WIDTH = 8
);

   logic                 cyc_i;
   logic                 stb_i;
   logic                 we_i;
   logic [DAT_WIDTH-1:0] dat_i;
   logic                 ack_o;
   logic                 err_o;
   logic                 rty_o;
   logic [DAT_WIDTH-1:0] dat_o;

   modport master (
      output cyc_i, stb_i, we_i, dat_i,
      input  ack_o, err_o, rty_o, dat_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, dat_i,
      output ack_o, err_o, rty_o, dat_o
   );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty come from comparing
// the wrap bit and the index bits of the two pointers.
module sync_fifo #(
   parameter int DAT_WIDTH = 8,
   parameter int DEPTH     = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DAT_WIDTH-1:0]     wdata,
   output logic [DAT_WIDTH-1:0]     rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [DAT_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/wishbone_fifo_device.sv
// Wishbone classic responder: writes push into a FIFO mailbox, reads pop from
// it, with optional wait states and ack/err/rty terminations.
module wishbone_fifo_device
   import wb_fifo_pkg::*;
#(
   parameter int DAT_WIDTH   = 8,
   parameter int DEPTH       = 4,
   parameter int WAIT_STATES = 0,
   parameter bit RETRY_EN    = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   wishbone_fifo_device_if.slave  wb,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam term_t FAIL_TERM = RETRY_EN ? TERM_RTY : TERM_ERR;

   state_t                state;
   state_t                state_nxt;
   logic                  enter_resp;
   logic                  req;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  we_q;
   logic [DAT_WIDTH-1:0]  dat_q;
   logic                  cur_we;
   logic [DAT_WIDTH-1:0]  cur_dat;
   term_t                 term;
   logic [DAT_WIDTH-1:0]  rd_q;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [DAT_WIDTH-1:0]  fifo_rdata;

   assign req = wb.cyc_i && wb.stb_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   // The wait counter reaching zero commits even if cyc_i drops on that edge.
   always_comb begin
      state_nxt  = state;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == '0) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end else if (!wb.cyc_i) begin
               state_nxt = IDLE;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt <= '0;
         we_q     <= 1'b0;
         dat_q    <= '0;
      end else if (state == IDLE && req) begin
         wait_cnt <= WAIT_LOAD;
         we_q     <= wb.we_i;
         dat_q    <= wb.dat_i;
      end else if (state == WAIT && wait_cnt != '0) begin
         wait_cnt <= wait_cnt - 1'b1;
      end
   end

   // With no wait states the commit edge is the capture edge, so use live inputs.
   assign cur_we  = (state == IDLE) ? wb.we_i  : we_q;
   assign cur_dat = (state == IDLE) ? wb.dat_i : dat_q;
   assign push    = enter_resp &&  cur_we && !full;
   assign pop     = enter_resp && !cur_we && !empty;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         term <= TERM_NONE;
         rd_q <= '0;
      end else if (enter_resp) begin
         term <= (push || pop) ? TERM_ACK : FAIL_TERM;
         rd_q <= pop ? fifo_rdata : '0;
      end else begin
         term <= TERM_NONE;
         rd_q <= '0;
      end
   end

   assign wb.ack_o = (term == TERM_ACK);
   assign wb.err_o = (term == TERM_ERR);
   assign wb.rty_o = (term == TERM_RTY);
   assign wb.dat_o = rd_q;

   sync_fifo #(
      .DAT_WIDTH(DAT_WIDTH),
      .DEPTH    (DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .push  (push),
      .pop   (pop),
      .wdata (cur_dat),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .level (level_o)
   );

endmodule
